filt_cicd_mc: RTL and testbench

Multi-channel, runtime-rate-programmable CIC decimator with output scaling.
- Accepts time-multiplexed samples for gp_nr_channels channels on one input bus.
- Runs an order-gp_order integrator/comb chain per channel, with state held in per-channel register banks.
- Decimates by a runtime rate R, then rounds, shifts and saturates to gp_oup_width.
- Sits between the modulator/front-end sample stream and downstream FIR compensation stages.

---
 rtl/filt_cicd_mc_if.sv | 33 +++
 rtl/filt_cicd_mc.sv | 163 ++++++++++++++++
 tb/tb_filt_cicd_mc.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/filt_cicd_mc_if.sv
// Sample and output bus of the multi-channel CIC decimator.
// master drives the sample stream and controls; slave is the decimator.
interface filt_cicd_mc_if #(
    parameter int gp_nr_channels = 2,
    parameter int gp_max_rate    = 16,
    parameter int gp_inp_width   = 8,
    parameter int gp_acc_width   = 20,
    parameter int gp_oup_width   = 16
);
    localparam int RATE_W  = $clog2(gp_max_rate + 1);
    localparam int SHIFT_W = $clog2(gp_acc_width);
    localparam int CHAN_W  = (gp_nr_channels > 1) ? $clog2(gp_nr_channels) : 1;

    logic                           i_clear;
    logic [RATE_W-1:0]              i_rate;
    logic [SHIFT_W-1:0]             i_shift;
    logic                           i_valid;
    logic signed [gp_inp_width-1:0] i_data;
    logic                           o_valid;
    logic [CHAN_W-1:0]              o_chan;
    logic signed [gp_oup_width-1:0] o_data;
    logic                           o_sat;

    modport master (
        output i_clear, i_rate, i_shift, i_valid, i_data,
        input  o_valid, o_chan, o_data, o_sat
    );

    modport slave (
        input  i_clear, i_rate, i_shift, i_valid, i_data,
        output o_valid, o_chan, o_data, o_sat
    );
endinterface

// File: rtl/filt_cicd_mc.sv
// Multi-channel TDM CIC decimator with runtime rate, rounding shift and output saturation.
// Integrator/comb state lives in per-channel register banks indexed by the channel counter.
module filt_cicd_mc #(
    parameter int gp_nr_channels = 2,
    parameter int gp_max_rate    = 16,
    parameter int gp_order       = 3,
    parameter int gp_diff_delay  = 1,
    parameter int gp_inp_width   = 8,
    parameter int gp_acc_width   = gp_inp_width + gp_order * $clog2(gp_max_rate * gp_diff_delay),
    parameter int gp_oup_width   = 16
) (
    input logic           i_clk,
    input logic           i_rst_an,
    filt_cicd_mc_if.slave bus
);
    localparam int ACC_W   = gp_acc_width;
    localparam int RATE_W  = $clog2(gp_max_rate + 1);
    localparam int SHIFT_W = $clog2(gp_acc_width);
    localparam int CHAN_W  = (gp_nr_channels > 1) ? $clog2(gp_nr_channels) : 1;
    localparam int FRM_W   = $clog2(gp_max_rate);

    localparam logic [CHAN_W-1:0] LAST_CH  = CHAN_W'(gp_nr_channels - 1);
    localparam logic [RATE_W-1:0] MIN_RATE = RATE_W'(2);
    localparam logic [RATE_W-1:0] MAX_RATE = RATE_W'(gp_max_rate);
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W - gp_oup_width + 2){1'b0}}, {(gp_oup_width - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN =
        {{(ACC_W - gp_oup_width + 2){1'b1}}, {(gp_oup_width - 1){1'b0}}};

    typedef logic signed [ACC_W-1:0] acc_t;

    acc_t integ [gp_nr_channels][gp_order];
    acc_t dly   [gp_nr_channels][gp_order][gp_diff_delay];

    logic [CHAN_W-1:0]              ch_cnt;
    logic [FRM_W-1:0]               frm_cnt;
    logic [FRM_W-1:0]               rate_m1;
    logic [SHIFT_W-1:0]             shift_q;
    logic                           out_valid;
    logic [CHAN_W-1:0]              out_chan;
    logic signed [gp_oup_width-1:0] out_data;
    logic                           out_sat;

    acc_t                           integ_nxt [gp_order];
    acc_t                           comb_in   [gp_order];
    acc_t                           chain;
    acc_t                           comb_out;
    logic signed [ACC_W:0]          rnd_half;
    logic signed [ACC_W:0]          rnd_sum;
    logic signed [ACC_W:0]          shifted;
    logic signed [gp_oup_width-1:0] sat_data;
    logic                           sat_flag;
    logic [RATE_W-1:0]              rate_clamped;
    logic                           last_ch;
    logic                           dec_sample;

    // Integrators feed forward within the cycle, then the comb runs on the fresh integrator output.
    always_comb begin
        chain = acc_t'(bus.i_data);
        for (int k = 0; k < gp_order; k++) begin
            integ_nxt[k] = integ[ch_cnt][k] + chain;
            chain        = integ_nxt[k];
        end
        for (int k = 0; k < gp_order; k++) begin
            comb_in[k] = chain;
            chain      = chain - dly[ch_cnt][k][gp_diff_delay-1];
        end
        comb_out = chain;
    end

    // Round half up, arithmetic shift, then clamp into the output range.
    always_comb begin
        rnd_half = '0;
        if (shift_q != '0) begin
            rnd_half = (ACC_W + 1)'(1) << (shift_q - SHIFT_W'(1));
        end
        rnd_sum = (ACC_W + 1)'(comb_out) + rnd_half;
        shifted = rnd_sum >>> shift_q;
        if (shifted > SAT_MAX) begin
            sat_data = {1'b0, {(gp_oup_width - 1){1'b1}}};
            sat_flag = 1'b1;
        end else if (shifted < SAT_MIN) begin
            sat_data = {1'b1, {(gp_oup_width - 1){1'b0}}};
            sat_flag = 1'b1;
        end else begin
            sat_data = shifted[gp_oup_width-1:0];
            sat_flag = 1'b0;
        end
    end

    always_comb begin
        if (bus.i_rate < MIN_RATE) begin
            rate_clamped = MIN_RATE;
        end else if (bus.i_rate > MAX_RATE) begin
            rate_clamped = MAX_RATE;
        end else begin
            rate_clamped = bus.i_rate;
        end
        last_ch    = (ch_cnt == LAST_CH);
        dec_sample = (frm_cnt == rate_m1);
    end

    // Clear flushes the same state as reset but latches the new rate/shift.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            for (int c = 0; c < gp_nr_channels; c++) begin
                for (int k = 0; k < gp_order; k++) begin
                    integ[c][k] <= '0;
                    for (int j = 0; j < gp_diff_delay; j++) dly[c][k][j] <= '0;
                end
            end
            ch_cnt    <= '0;
            frm_cnt   <= '0;
            rate_m1   <= FRM_W'(gp_max_rate - 1);
            shift_q   <= '0;
            out_valid <= 1'b0;
            out_chan  <= '0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (bus.i_clear) begin
            for (int c = 0; c < gp_nr_channels; c++) begin
                for (int k = 0; k < gp_order; k++) begin
                    integ[c][k] <= '0;
                    for (int j = 0; j < gp_diff_delay; j++) dly[c][k][j] <= '0;
                end
            end
            ch_cnt    <= '0;
            frm_cnt   <= '0;
            rate_m1   <= FRM_W'(rate_clamped - RATE_W'(1));
            shift_q   <= bus.i_shift;
            out_valid <= 1'b0;
            out_chan  <= '0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (bus.i_valid) begin
                for (int k = 0; k < gp_order; k++) integ[ch_cnt][k] <= integ_nxt[k];
                ch_cnt <= last_ch ? '0 : ch_cnt + CHAN_W'(1);
                if (last_ch) begin
                    frm_cnt <= dec_sample ? '0 : frm_cnt + FRM_W'(1);
                end
                if (dec_sample) begin
                    for (int k = 0; k < gp_order; k++) begin
                        dly[ch_cnt][k][0] <= comb_in[k];
                        for (int j = 1; j < gp_diff_delay; j++) begin
                            dly[ch_cnt][k][j] <= dly[ch_cnt][k][j-1];
                        end
                    end
                    out_valid <= 1'b1;
                    out_chan  <= ch_cnt;
                    out_data  <= sat_data;
                    out_sat   <= sat_flag;
                end
            end
        end
    end

    assign bus.o_valid = out_valid;
    assign bus.o_chan  = out_chan;
    assign bus.o_data  = out_data;
    assign bus.o_sat   = out_sat;
endmodule

// File: tb/tb_filt_cicd_mc.sv
// Bench for filt_cicd_mc: dut A is single-channel 16-bit out, dut B is two-channel 8-bit out.
// Order 3, M=1, max rate 16, so steady DC gain is R^3.
module tb_filt_cicd_mc;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    filt_cicd_mc_if #(.gp_nr_channels(1), .gp_max_rate(16), .gp_inp_width(8),
                      .gp_acc_width(20), .gp_oup_width(16)) if_a ();
    filt_cicd_mc_if #(.gp_nr_channels(2), .gp_max_rate(16), .gp_inp_width(8),
                      .gp_acc_width(20), .gp_oup_width(8)) if_b ();

    filt_cicd_mc #(.gp_nr_channels(1), .gp_max_rate(16), .gp_order(3), .gp_diff_delay(1),
                   .gp_inp_width(8), .gp_oup_width(16)) u_a (
        .i_clk(clk), .i_rst_an(rst_n), .bus(if_a));
    filt_cicd_mc #(.gp_nr_channels(2), .gp_max_rate(16), .gp_order(3), .gp_diff_delay(1),
                   .gp_inp_width(8), .gp_oup_width(8)) u_b (
        .i_clk(clk), .i_rst_an(rst_n), .bus(if_b));

    typedef struct {
        int dut;
        int dc0;
        int dc1;
        int rate;
        int shift;
        int gap;
        int exp0;
        int sat0;
        int exp1;
        int sat1;
    } vec_t;

    vec_t vecs[$];
    int tests = 0;
    int fails = 0;
    int qa_data[$], qa_sat[$];
    int qb_data[$], qb_sat[$], qb_chan[$], qb_cyc[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_in(input int dut, input bit clr, input int rate, input int shift,
                          input bit v, input int d);
        if (dut == 0) begin
            if_a.i_clear = clr; if_a.i_rate = 5'(rate); if_a.i_shift = 5'(shift);
            if_a.i_valid = v;   if_a.i_data = 8'(d);
        end else begin
            if_b.i_clear = clr; if_b.i_rate = 5'(rate); if_b.i_shift = 5'(shift);
            if_b.i_valid = v;   if_b.i_data = 8'(d);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (if_a.o_valid) begin
            qa_data.push_back(int'(if_a.o_data));
            qa_sat.push_back(int'(if_a.o_sat));
        end
        if (if_b.o_valid) begin
            qb_data.push_back(int'(if_b.o_data));
            qb_sat.push_back(int'(if_b.o_sat));
            qb_chan.push_back(int'(if_b.o_chan));
            qb_cyc.push_back(cyc);
        end
    endtask

    task automatic flush();
        qa_data.delete(); qa_sat.delete();
        qb_data.delete(); qb_sat.delete(); qb_chan.delete(); qb_cyc.delete();
    endtask

    function automatic int cur_valid(input int dut);
        return (dut == 0) ? int'(if_a.o_valid) : int'(if_b.o_valid);
    endfunction

    function automatic int cur_data(input int dut);
        return (dut == 0) ? int'(if_a.o_data) : int'(if_b.o_data);
    endfunction

    function automatic int clamp_rate(input int r);
        return (r < 2) ? 2 : ((r > 16) ? 16 : r);
    endfunction

    // Clear (with a simultaneous sample), then 4 output periods of DC per channel, then one idle cycle.
    task automatic apply_stimulus(input vec_t v, input int idx);
        int n;
        int re;
        n  = (v.dut == 0) ? 1 : 2;
        re = clamp_rate(v.rate);
        set_in(v.dut, 1'b1, v.rate, v.shift, 1'b1, v.dc0);
        step();
        check($sformatf("v%0d_clear_valid", idx), cur_valid(v.dut), 0);
        flush();
        for (int i = 0; i < 4 * re * n; i++) begin
            set_in(v.dut, 1'b0, 0, 0, 1'b1, (n == 2 && (i % 2) == 1) ? v.dc1 : v.dc0);
            step();
            if (v.gap != 0) begin
                set_in(v.dut, 1'b0, 0, 0, 1'b0, 0);
                step();
            end
        end
        set_in(v.dut, 1'b0, 0, 0, 1'b0, 0);
        step();
    endtask

    task automatic check_output(input vec_t v, input int idx);
        int re;
        re = clamp_rate(v.rate);
        check($sformatf("v%0d_idle_valid", idx), cur_valid(v.dut), 0);
        if (v.dut == 0) begin
            check($sformatf("v%0d_count", idx), qa_data.size(), 4);
            check($sformatf("v%0d_hold", idx), cur_data(0), v.exp0);
            if (qa_data.size() >= 4) begin
                for (int k = 2; k < 4; k++) begin
                    check($sformatf("v%0d_data%0d", idx, k), qa_data[k], v.exp0);
                    check($sformatf("v%0d_sat%0d", idx, k), qa_sat[k], v.sat0);
                end
            end
        end else begin
            check($sformatf("v%0d_count", idx), qb_data.size(), 8);
            check($sformatf("v%0d_hold", idx), cur_data(1), v.exp1);
            if (qb_data.size() >= 8) begin
                for (int k = 4; k < 8; k++) begin
                    check($sformatf("v%0d_chan%0d", idx, k), qb_chan[k], k % 2);
                    check($sformatf("v%0d_data%0d", idx, k), qb_data[k],
                          (k % 2 == 0) ? v.exp0 : v.exp1);
                    check($sformatf("v%0d_sat%0d", idx, k), qb_sat[k],
                          (k % 2 == 0) ? v.sat0 : v.sat1);
                end
                check($sformatf("v%0d_pair_gap", idx), qb_cyc[5] - qb_cyc[4], v.gap + 1);
                check($sformatf("v%0d_period", idx), qb_cyc[6] - qb_cyc[4],
                      2 * re * (v.gap + 1));
            end
        end
    endtask

    initial begin
        //                dut dc0   dc1   rate sh gap exp0    sat0 exp1  sat1
        vecs.push_back('{0,   1,    0,    4,   0, 0,  64,     0,   0,    0});
        vecs.push_back('{0,   -128, 0,    4,   0, 0,  -8192,  0,   0,    0});
        vecs.push_back('{0,   1,    0,    4,   3, 0,  8,      0,   0,    0});
        vecs.push_back('{0,   1,    0,    4,   7, 0,  1,      0,   0,    0});
        vecs.push_back('{0,   3,    0,    4,   6, 0,  3,      0,   0,    0});
        vecs.push_back('{0,   1,    0,    8,   0, 0,  512,    0,   0,    0});
        vecs.push_back('{0,   1,    0,    1,   0, 0,  8,      0,   0,    0});
        vecs.push_back('{0,   1,    0,    31,  0, 0,  4096,   0,   0,    0});
        vecs.push_back('{0,   1,    0,    4,   0, 1,  64,     0,   0,    0});
        vecs.push_back('{0,   -3,   0,    4,   7, 0,  -1,     0,   0,    0});
        vecs.push_back('{0,   127,  0,    16,  0, 0,  32767,  1,   0,    0});
        vecs.push_back('{0,   -128, 0,    16,  0, 0,  -32768, 1,   0,    0});
        vecs.push_back('{0,   127,  0,    16,  5, 0,  16256,  0,   0,    0});
        vecs.push_back('{1,   1,    -1,   4,   0, 0,  64,     0,   -64,  0});
        vecs.push_back('{1,   127,  -128, 4,   0, 0,  127,    1,   -128, 1});
        vecs.push_back('{1,   1,    -1,   4,   0, 1,  64,     0,   -64,  0});
        vecs.push_back('{1,   2,    1,    4,   2, 0,  32,     0,   16,   0});
        vecs.push_back('{1,   2,    -2,   4,   0, 0,  127,    1,   -128, 0});

        set_in(0, 1'b0, 16, 0, 1'b0, 0);
        set_in(1, 1'b0, 16, 0, 1'b0, 0);
        #1 rst_n = 1'b0;
        #1;
        check("rst_a_valid", int'(if_a.o_valid), 0);
        check("rst_a_data", int'(if_a.o_data), 0);
        check("rst_a_sat", int'(if_a.o_sat), 0);
        check("rst_a_chan", int'(if_a.o_chan), 0);
        check("rst_b_valid", int'(if_b.o_valid), 0);
        check("rst_b_data", int'(if_b.o_data), 0);
        #8 rst_n = 1'b1;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i], i);
            check_output(vecs[i], i);
        end

        // Start-up ramp of a fresh R=4 DC-1 stream.
        apply_stimulus(vecs[0], 100);
        if (qa_data.size() >= 2) begin
            check("ramp_out0", qa_data[0], 20);
            check("ramp_out1", qa_data[1], 60);
        end else begin
            check("ramp_count", qa_data.size(), 4);
        end

        // Clear on what would have been a decimation sample, re-latching R=8.
        set_in(0, 1'b1, 4, 0, 1'b0, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1'b0, 0, 0, 1'b1, 1);
            step();
        end
        set_in(0, 1'b1, 8, 0, 1'b1, 1);
        step();
        check("clear_prio_valid", int'(if_a.o_valid), 0);
        flush();
        for (int i = 0; i < 32; i++) begin
            set_in(0, 1'b0, 0, 0, 1'b1, 1);
            step();
        end
        set_in(0, 1'b0, 0, 0, 1'b0, 0);
        step();
        check("r8_count", qa_data.size(), 4);
        if (qa_data.size() >= 4) begin
            check("r8_out0", qa_data[0], 120);
            check("r8_out2", qa_data[2], 512);
            check("r8_out3", qa_data[3], 512);
        end

        // Asynchronous reset in the middle of a frame.
        for (int i = 0; i < 2; i++) begin
            set_in(0, 1'b0, 0, 0, 1'b1, 1);
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_a_data", int'(if_a.o_data), 0);
        check("arst_a_valid", int'(if_a.o_valid), 0);
        check("arst_b_data", int'(if_b.o_data), 0);
        #1 rst_n = 1'b1;
        flush();
        for (int i = 0; i < 64; i++) begin
            set_in(0, 1'b0, 0, 0, 1'b1, 1);
            step();
        end
        set_in(0, 1'b0, 0, 0, 1'b0, 0);
        step();
        check("arst_count", qa_data.size(), 4);
        if (qa_data.size() >= 4) begin
            check("arst_out0", qa_data[0], 816);
            check("arst_out2", qa_data[2], 4096);
            check("arst_out3", qa_data[3], 4096);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
